// File: rtl/lsu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_arb_pkg
//  Description : Shared types for the two-master LSU arbiter: arbitration
//                state, issue-stage owner tag and the registered LSU request.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_arb_pkg;

  // Owner of the most recent grant
  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_CORE     = 2'd1,
    ARB_DMA      = 2'd2,
    ARB_DMA_LOCK = 2'd3
  } arb_state_e;

  // Owner tag carried with a request through the issue and response stages
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_C    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [2:0]  bmask;
  } lsu_req_t;

  // Bundle a requester's payload into one request word
  function automatic lsu_req_t pack_req(input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic        wren,
                                        input logic [2:0]  bmask);
    lsu_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.wren  = wren;
    r.bmask = bmask;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_arb_prio
//  Description : Winner select for the LSU port. Core has fixed priority,
//                the DMA master is forced through after STARVE_LIMIT
//                consecutive core grants, and a DMA lock holds the port for
//                up to LOCK_MAX beats before yielding once to the core.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_arb_prio
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic c_valid,
  input  logic d_valid,
  input  logic d_lock,
  output logic grant_c,
  output logic grant_d
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int LW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

  arb_state_e    state, next_state;
  logic [SW-1:0] starve_cnt, next_starve;
  logic [LW-1:0] lock_cnt, next_lock;
  logic          win_c, win_d, hold;
  logic          lock_live;

  // Arbitration state and fairness counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_starve;
      lock_cnt   <= next_lock;
    end
  end

  // Winner select and next-state / counter update
  always_comb begin
    next_state  = state;
    next_starve = starve_cnt;
    next_lock   = lock_cnt;
    win_c       = 1'b0;
    win_d       = 1'b0;
    hold        = 1'b0;

    // The lock only binds while the burst is still under its beat budget
    lock_live = (state == ARB_DMA_LOCK) && (lock_cnt < LOCK_TOP);

    if (lock_live && d_valid) begin
      win_d = 1'b1;
    end else if ((starve_cnt == STARVE_MAX) && d_valid) begin
      win_d = 1'b1;
    end else if (lock_live && d_lock) begin
      // Locked master paused between beats: keep the port reserved for it
      hold = 1'b1;
    end else if (c_valid) begin
      win_c = 1'b1;
    end else if (d_valid) begin
      win_d = 1'b1;
    end

    if (win_d) begin
      next_starve = '0;
      if (d_lock) begin
        next_state = ARB_DMA_LOCK;
        // A beat taken after the budget ran out starts a fresh window
        next_lock  = (lock_cnt >= LOCK_TOP) ? LOCK_ONE : lock_cnt + LOCK_ONE;
      end else begin
        next_state = ARB_DMA;
        next_lock  = '0;
      end
    end else if (win_c) begin
      next_state  = ARB_CORE;
      next_lock   = '0;
      if (!d_valid)
        next_starve = '0;
      else if (starve_cnt != STARVE_MAX)
        next_starve = starve_cnt + STARVE_ONE;
    end else if (hold) begin
      next_starve = '0;
    end else begin
      next_state  = ARB_IDLE;
      next_lock   = '0;
      next_starve = '0;
    end

    // Nothing may be accepted while reset is asserted
    grant_c = win_c & ~rst;
    grant_d = win_d & ~rst;
  end

endmodule
`default_nettype wire

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_arbiter
//  Description : Shares the single LSU port between the core datapath (C)
//                and a debug/DMA master (D). The granted request is
//                registered onto the LSU inputs; load data is captured one
//                cycle later and returned to its owner for exactly one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_c_valid,
  output logic        o_c_ready,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic        i_c_wren,
  input  logic [2:0]  i_c_bmask,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  input  logic        i_d_valid,
  output logic        o_d_ready,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic        i_d_wren,
  input  logic [2:0]  i_d_bmask,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  input  logic        i_d_lock,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_lsu_bmask,
  input  logic [31:0] i_lsu_ld_data,
  output logic [1:0]  o_owner
);

  logic        grant_c, grant_d;
  lsu_req_t    sel_req;
  lsu_req_t    issue_req;
  logic        issue_valid;
  owner_e      issue_owner;
  logic        resp_valid;
  owner_e      resp_owner;
  logic [31:0] resp_data;

  lsu_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .LOCK_MAX     (LOCK_MAX)
  ) u_prio (
    .clk     (i_clk),
    .rst     (i_reset),
    .c_valid (i_c_valid),
    .d_valid (i_d_valid),
    .d_lock  (i_d_lock),
    .grant_c (grant_c),
    .grant_d (grant_d)
  );

  assign o_c_ready = grant_c;
  assign o_d_ready = grant_d;

  // Payload mux for the winning requester
  always_comb begin
    sel_req = '0;
    if (grant_d)
      sel_req = pack_req(i_d_addr, i_d_wdata, i_d_wren, i_d_bmask);
    else if (grant_c)
      sel_req = pack_req(i_c_addr, i_c_wdata, i_c_wren, i_c_bmask);
  end

  // Issue stage: holds the accepted request for one cycle on the LSU inputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      issue_valid <= 1'b0;
      issue_owner <= OWN_NONE;
      issue_req   <= '0;
    end else if (grant_c || grant_d) begin
      issue_valid <= 1'b1;
      issue_owner <= grant_d ? OWN_D : OWN_C;
      issue_req   <= sel_req;
    end else begin
      issue_valid <= 1'b0;
      issue_owner <= OWN_NONE;
      issue_req   <= '0;
    end
  end

  // Response stage: captures the LSU's combinational load data at the end
  // of the issue cycle; stores return a zero data word
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      resp_valid <= 1'b0;
      resp_owner <= OWN_NONE;
      resp_data  <= '0;
    end else begin
      resp_valid <= issue_valid;
      resp_owner <= issue_owner;
      resp_data  <= (issue_valid && !issue_req.wren) ? i_lsu_ld_data : '0;
    end
  end

  assign o_lsu_addr    = issue_valid ? issue_req.addr  : '0;
  assign o_lsu_st_data = issue_valid ? issue_req.wdata : '0;
  assign o_lsu_bmask   = issue_valid ? issue_req.bmask : '0;
  assign o_lsu_wren    = issue_valid & issue_req.wren;
  assign o_owner       = issue_owner;

  assign o_c_rvalid = resp_valid && (resp_owner == OWN_C);
  assign o_d_rvalid = resp_valid && (resp_owner == OWN_D);
  assign o_c_rdata  = o_c_rvalid ? resp_data : '0;
  assign o_d_rdata  = o_d_rvalid ? resp_data : '0;

endmodule
`default_nettype wire
